sap_mem_bridge: RTL and testbench

Parametrised memory bridge between the SAP-3 core's memory strobes and a single-port IHP SRAM macro. Holds the 16-bit MAR, packs DATA_W-wide CPU bytes into SRAM_W-wide words via byte-lane masks (no wasted upper bits), sequences writes and fixed-latency reads with a busy/rvalid handshake, and flags out-of-range and overrun accesses. Sits between `heichips25_sap3` pin decode and the SRAM wrapper in the chip top and bench tops.

---
 rtl/sap_mem_pkg.sv | 28 ++
 rtl/sap_rd_pipe.sv | 44 ++++
 rtl/sap_mem_bridge.sv | 146 ++++++++++++++
 tb/tb_sap_mem_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_mem_pkg.sv
// sap_mem_bridge shared types: FSM state, lane geometry helpers, lane mask.
package sap_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_WAIT
    } state_t;

    localparam int MASK_W = 256;

    function automatic int lanes_of(input int sram_w, input int data_w);
        return sram_w / data_w;
    endfunction

    function automatic int lb_of(input int sram_w, input int data_w);
        return $clog2(sram_w / data_w);
    endfunction

    function automatic logic [MASK_W-1:0] lane_mask(input int lane,
                                                    input int data_w);
        logic [MASK_W-1:0] m;
        m = (MASK_W'(1) << data_w) - MASK_W'(1);
        return m << (lane * data_w);
    endfunction

endpackage

// File: rtl/sap_rd_pipe.sv
// Read-latency shift register: carries valid, lane and out-of-range flag
// from the SRAM read strobe to the rdata capture point.
module sap_rd_pipe
    import sap_mem_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int LW     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_v,
    input  logic [LW-1:0] in_lane,
    input  logic          in_oor,
    output logic          cap,
    output logic [LW-1:0] cap_lane,
    output logic          cap_oor
);

    logic [RD_LAT-1:0]         v_q;
    logic [RD_LAT-1:0]         oor_q;
    logic [RD_LAT-1:0][LW-1:0] lane_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            oor_q  <= '0;
            lane_q <= '0;
        end else begin
            v_q[0]    <= in_v;
            oor_q[0]  <= in_oor;
            lane_q[0] <= in_lane;
            for (int i = 1; i < RD_LAT; i++) begin
                v_q[i]    <= v_q[i-1];
                oor_q[i]  <= oor_q[i-1];
                lane_q[i] <= lane_q[i-1];
            end
        end
    end

    assign cap      = v_q[RD_LAT-1];
    assign cap_oor  = oor_q[RD_LAT-1];
    assign cap_lane = lane_q[RD_LAT-1];

endmodule

// File: rtl/sap_mem_bridge.sv
// SAP-3 MAR / byte-lane bridge to a single-port SRAM macro.
// Optional: define SAP_MAR_AUTOINC_EN for MAR post-increment on accepted requests.
module sap_mem_bridge
    import sap_mem_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int SRAM_W = 32,
    parameter int RD_LAT = 1,
    localparam int LB    = lb_of(SRAM_W, DATA_W),
    localparam int AW    = ADDR_W - LB
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mar_we,
    input  logic [15:0]       mar_addr,
    input  logic              ram_we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_req,
    input  logic              err_clr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              err_oor,
    output logic              err_ovr,
    output logic [AW-1:0]     sram_addr,
    output logic [SRAM_W-1:0] sram_bm,
    output logic [SRAM_W-1:0] sram_din,
    output logic              sram_men,
    output logic              sram_wen,
    output logic              sram_ren,
    input  logic [SRAM_W-1:0] sram_dout
);

    localparam int LANES = lanes_of(SRAM_W, DATA_W);
    localparam int LW    = (LB > 0) ? LB : 1;

    state_t          state, state_nx;
    logic [15:0]     mar, mar_nx, ea;
    logic            oor, acc_wr, acc_rd, drop;
    logic [AW-1:0]   word;
    logic [LW-1:0]   lane, rd_lane, cap_lane;
    logic            rd_oor, cap, cap_oor;

    assign ea   = mar_we ? mar_addr : mar;
    assign oor  = (ea >> ADDR_W) != 16'd0;
    assign word = AW'(ea[ADDR_W-1:0] >> LB);
    assign lane = LW'(ea & 16'(LANES - 1));

    always_comb begin
        state_nx = state;
        acc_wr   = 1'b0;
        acc_rd   = 1'b0;
        drop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ram_we) begin
                    acc_wr   = 1'b1;
                    drop     = rd_req;
                    state_nx = ST_WR;
                end else if (rd_req) begin
                    acc_rd   = 1'b1;
                    state_nx = ST_RD_ISSUE;
                end
            end
            ST_WR: begin
                drop     = ram_we | rd_req;
                state_nx = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                drop     = ram_we | rd_req;
                state_nx = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                drop = ram_we | rd_req;
                if (cap) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        mar_nx = ea;
`ifdef SAP_MAR_AUTOINC_EN
        if (acc_wr || acc_rd) mar_nx = ea + 16'd1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mar       <= '0;
            busy      <= 1'b0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            err_oor   <= 1'b0;
            err_ovr   <= 1'b0;
            sram_addr <= '0;
            sram_bm   <= '0;
            sram_din  <= '0;
            sram_men  <= 1'b0;
            sram_wen  <= 1'b0;
            sram_ren  <= 1'b0;
            rd_lane   <= '0;
            rd_oor    <= 1'b0;
        end else begin
            state    <= state_nx;
            mar      <= mar_nx;
            busy     <= state_nx != ST_IDLE;
            sram_men <= (acc_wr | acc_rd) & ~oor;
            sram_wen <= acc_wr & ~oor;
            sram_ren <= acc_rd & ~oor;
            sram_addr <= (acc_wr | acc_rd) ? word : '0;
            sram_bm  <= (acc_wr & ~oor) ?
                        SRAM_W'(lane_mask(int'(lane), DATA_W)) : '0;
            sram_din <= (acc_wr & ~oor) ? {LANES{wdata}} : '0;
            if (acc_rd) begin
                rd_lane <= lane;
                rd_oor  <= oor;
            end
            rvalid <= cap;
            // Out-of-range reads still complete, but return zero
            if (cap)
                rdata <= cap_oor ? '0 : sram_dout[cap_lane*DATA_W +: DATA_W];
            if ((acc_wr | acc_rd) & oor) err_oor <= 1'b1;
            else if (err_clr)           err_oor <= 1'b0;
            if (drop)         err_ovr <= 1'b1;
            else if (err_clr) err_ovr <= 1'b0;
        end
    end

    sap_rd_pipe #(
        .RD_LAT (RD_LAT),
        .LW     (LW)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_v     (state == ST_RD_ISSUE),
        .in_lane  (rd_lane),
        .in_oor   (rd_oor),
        .cap      (cap),
        .cap_lane (cap_lane),
        .cap_oor  (cap_oor)
    );

endmodule

// File: tb/tb_sap_mem_bridge.sv
// Randomized self-checking bench for sap_mem_bridge against a byte-array model.
`timescale 1ns/1ps
module tb_sap_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mar_we = 1'b0;
    logic [15:0] mar_addr = '0;
    logic        ram_we = 1'b0;
    logic [7:0]  wdata = '0;
    logic        rd_req = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  rdata;
    logic        rvalid, busy, err_oor, err_ovr;
    logic [9:0]  sram_addr;
    logic [31:0] sram_bm, sram_din;
    logic        sram_men, sram_wen, sram_ren;
    logic [31:0] sram_dout = '0;

    sap_mem_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mar_we    (mar_we),
        .mar_addr  (mar_addr),
        .ram_we    (ram_we),
        .wdata     (wdata),
        .rd_req    (rd_req),
        .err_clr   (err_clr),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .busy      (busy),
        .err_oor   (err_oor),
        .err_ovr   (err_ovr),
        .sram_addr (sram_addr),
        .sram_bm   (sram_bm),
        .sram_din  (sram_din),
        .sram_men  (sram_men),
        .sram_wen  (sram_wen),
        .sram_ren  (sram_ren),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    // SRAM macro: 1024 x 32, bit-masked write, one-cycle read latency
    logic [31:0] smem [1024];
    always @(posedge clk) begin
        if (sram_men && sram_wen)
            smem[sram_addr] <= (smem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
        if (sram_men && sram_ren)
            sram_dout <= smem[sram_addr];
    end

    // Reference model: flat byte memory plus architectural registers
    logic [7:0]  rmem [4096];
    logic [15:0] mar_m = '0;
    logic [7:0]  last_rd = '0;
    logic        eoor_m = 1'b0;
    logic        eovr_m = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        mar_we  = 1'b0;
        ram_we  = 1'b0;
        rd_req  = 1'b0;
        err_clr = 1'b0;
    endtask

    function automatic logic [15:0] after_acc(input logic [15:0] ea);
`ifdef SAP_MAR_AUTOINC_EN
        return ea + 16'd1;
`else
        return ea;
`endif
    endfunction

    task automatic do_write(input logic use_mar, input logic [15:0] a,
                            input logic [7:0] d);
        logic [15:0] ea;
        logic        inr;
        ea  = use_mar ? a : mar_m;
        inr = ea < 16'd4096;
        mar_we = use_mar; mar_addr = a; ram_we = 1'b1; wdata = d;
        tick;
        idle_in;
        if (inr) rmem[ea[11:0]] = d;
        else     eoor_m = 1'b1;
        mar_m = after_acc(ea);
        check("wr_busy", busy, 1);
        check("wr_wen", sram_wen, inr);
        check("wr_men", sram_men, inr);
        check("wr_ren", sram_ren, 0);
        if (inr) begin
            check("wr_addr", sram_addr, ea >> 2);
            check("wr_bm", sram_bm, 32'hFF << {ea[1:0], 3'b000});
            check("wr_din", sram_din, {4{d}});
        end
        check("wr_oor", err_oor, eoor_m);
        tick;
        check("wr_done", busy, 0);
        check("rd_hold", rdata, last_rd);
        check("wr_ovr", err_ovr, eovr_m);
    endtask

    task automatic do_read(input logic use_mar, input logic [15:0] a);
        logic [15:0] ea;
        logic        inr;
        logic [7:0]  exp;
        ea  = use_mar ? a : mar_m;
        inr = ea < 16'd4096;
        exp = inr ? rmem[ea[11:0]] : 8'h00;
        mar_we = use_mar; mar_addr = a; rd_req = 1'b1;
        tick;
        idle_in;
        if (!inr) eoor_m = 1'b1;
        mar_m = after_acc(ea);
        check("rd_busy1", busy, 1);
        check("rd_ren", sram_ren, inr);
        check("rd_men", sram_men, inr);
        if (inr) check("rd_addr", sram_addr, ea >> 2);
        tick;
        check("rd_busy2", busy, 1);
        check("rd_early", rvalid, 0);
        tick;
        check("rd_rvalid", rvalid, 1);
        check("rd_data", rdata, exp);
        check("rd_free", busy, 0);
        check("rd_oor", err_oor, eoor_m);
        last_rd = exp;
        tick;
        check("rd_pulse", rvalid, 0);
        check("rd_keep", rdata, exp);
    endtask

    task automatic clr_cycle;
        err_clr = 1'b1;
        tick;
        idle_in;
        eoor_m = 1'b0;
        eovr_m = 1'b0;
        check("clr_oor", err_oor, 0);
        check("clr_ovr", err_ovr, 0);
    endtask

    initial begin
        int nv;
        logic [15:0] a;
        int r;
        for (int i = 0; i < 1024; i++) smem[i] = '0;
        for (int i = 0; i < 4096; i++) rmem[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick;

        check("rst_rdata", rdata, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", {err_oor, err_ovr}, 0);
        check("rst_en", {sram_men, sram_wen, sram_ren}, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_bm", sram_bm, 0);
        check("rst_din", sram_din, 0);

        do_write(1'b1, 16'h0005, 8'hA5);

        do_write(1'b1, 16'h0010, 8'h11);
        do_write(1'b1, 16'h0011, 8'h22);
        do_write(1'b1, 16'h0012, 8'h33);
        do_write(1'b1, 16'h0013, 8'h44);
        do_read(1'b1, 16'h0012);
        check("word4", smem[4], 32'h44332211);

        do_read(1'b1, 16'h1000);
        check("oor_set", err_oor, 1);
        clr_cycle;

        // Second read while busy is dropped
        mar_we = 1'b1; mar_addr = 16'h0012; rd_req = 1'b1;
        tick;
        mar_we = 1'b0;
        tick;
        idle_in;
        mar_m  = after_acc(16'h0012);
        eovr_m = 1'b1;
        check("ovr_set", err_ovr, 1);
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            if (rvalid) begin
                nv++;
                check("ovr_data", rdata, 8'h33);
            end
            tick;
        end
        check("ovr_single_rv", nv, 1);
        last_rd = 8'h33;
        clr_cycle;

        // Write/read collision while clearing: write wins, set beats clear
        mar_we = 1'b1; mar_addr = 16'h0030; ram_we = 1'b1; rd_req = 1'b1;
        wdata = 8'h5C; err_clr = 1'b1;
        tick;
        idle_in;
        rmem[12'h030] = 8'h5C;
        mar_m  = after_acc(16'h0030);
        eovr_m = 1'b1;
        check("col_ovr", err_ovr, 1);
        check("col_wen", sram_wen, 1);
        check("col_ren", sram_ren, 0);
        tick;
        do_read(1'b1, 16'h0030);

        // Asynchronous reset during RD_WAIT
        mar_we = 1'b1; mar_addr = 16'h0010; rd_req = 1'b1;
        tick;
        idle_in;
        tick;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rv", rvalid, 0);
        check("arst_men", sram_men, 0);
        check("arst_rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mar_m = '0; eoor_m = 1'b0; eovr_m = 1'b0; last_rd = '0;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (rvalid) nv++;
        end
        check("arst_no_rv", nv, 0);
        do_read(1'b0, 16'hBEEF);

        // MAR at top of the 16-bit space
        do_write(1'b1, 16'hFFFF, 8'h77);
        do_read(1'b0, 16'h0000);
        clr_cycle;

        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 15) == 0)
                a = 16'($urandom_range(4096, 65535));
            else
                a = 16'($urandom_range(0, 4095));
            if (r < 5)
                do_write($urandom_range(0, 3) != 0, a, 8'($urandom));
            else if (r < 9)
                do_read($urandom_range(0, 3) != 0, a);
            else
                clr_cycle;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
